// File: rtl/ysyx_24110006_mem_arbiter.sv
// ysyx_24110006_mem_arbiter
// Shares the core's single memory-bus master port between the instruction
// fetch unit (read-only) and the load/store unit. Only one transaction is
// outstanding at a time. The LSU wins ties because it carries the older
// instruction, but after MAX_LSU_STREAK consecutive LSU grants taken while
// fetch was waiting, fetch is forced through. Fetch responses that a
// pipeline flush has made stale are accepted from the bus and discarded here.
//
// Ports
//   i_clock, i_reset          core clock, async active-high reset
//   i_ifu_* / o_ifu_*         fetch request (addr) and response (rdata, err),
//                             i_ifu_flush kills the fetch in flight
//   i_lsu_* / o_lsu_*         load/store request (addr, wen, wdata, wmask,
//                             size) and response (rdata, err)
//   o_bus_* / i_bus_*         master port toward the bus bridge
//   o_busy, o_owner           state != IDLE; current owner (0 = IFU, 1 = LSU)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction; grant decided combinationally from the requests
// ISSUE | latched request presented on the bus until i_bus_req_ready
// WAIT  | waiting for the bus response; routed to the owner or dropped

module ysyx_24110006_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,

    input  logic              i_ifu_req_valid,
    output logic              o_ifu_req_ready,
    input  logic [ADDR_W-1:0] i_ifu_addr,
    input  logic              i_ifu_flush,
    output logic              o_ifu_resp_valid,
    input  logic              i_ifu_resp_ready,
    output logic [31:0]       o_ifu_rdata,
    output logic              o_ifu_err,

    input  logic              i_lsu_req_valid,
    output logic              o_lsu_req_ready,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic              i_lsu_wen,
    input  logic [31:0]       i_lsu_wdata,
    input  logic [3:0]        i_lsu_wmask,
    input  logic [2:0]        i_lsu_size,
    output logic              o_lsu_resp_valid,
    input  logic              i_lsu_resp_ready,
    output logic [31:0]       o_lsu_rdata,
    output logic              o_lsu_err,

    output logic              o_bus_req_valid,
    input  logic              i_bus_req_ready,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic              o_bus_wen,
    output logic [31:0]       o_bus_wdata,
    output logic [3:0]        o_bus_wmask,
    output logic [2:0]        o_bus_size,
    input  logic              i_bus_resp_valid,
    output logic              o_bus_resp_ready,
    input  logic [31:0]       i_bus_rdata,
    input  logic              i_bus_err,

    output logic              o_busy,
    output logic              o_owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);
    localparam logic       OWNER_IFU  = 1'b0;
    localparam logic       OWNER_LSU  = 1'b1;
    localparam logic [2:0] IFU_SIZE   = 3'b010;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              drop_q, drop_d;
    logic [3:0]        streak_q, streak_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [2:0]        size_q, size_d;

    logic ifu_live;
    logic lsu_win;
    logic ifu_win;
    logic owner_resp_ready;
    logic resp_ready_w;
    logic bus_resp_hs;

    // Grant and handshake terms shared by the next-state and output logic.
    always_comb begin
        ifu_live = i_ifu_req_valid & ~i_ifu_flush;
        lsu_win  = 1'b0;
        ifu_win  = 1'b0;
        if (state_q == ST_IDLE) begin
            // LSU yields only when fetch is live and has been starved long enough.
            lsu_win = i_lsu_req_valid & ~(ifu_live & (streak_q == STREAK_MAX));
            ifu_win = ifu_live & ~lsu_win;
        end
        owner_resp_ready = (owner_q == OWNER_LSU) ? i_lsu_resp_ready : i_ifu_resp_ready;
        // A dropped fetch response is swallowed regardless of the IFU's ready.
        resp_ready_w     = (state_q == ST_WAIT) & (drop_q | owner_resp_ready);
        bus_resp_hs      = resp_ready_w & i_bus_resp_valid;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWNER_IFU;
            drop_q   <= 1'b0;
            streak_q <= 4'd0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= 32'd0;
            wmask_q  <= 4'd0;
            size_q   <= 3'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            drop_q   <= drop_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            size_q   <= size_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (lsu_win | ifu_win) state_d = ST_ISSUE;
            ST_ISSUE: if (i_bus_req_ready)   state_d = ST_WAIT;
            ST_WAIT:  if (bus_resp_hs)       state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    // Payload, owner, streak and drop bookkeeping.
    always_comb begin
        owner_d  = owner_q;
        drop_d   = drop_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        size_d   = size_q;

        if (state_q == ST_IDLE) begin
            if (lsu_win) begin
                owner_d = OWNER_LSU;
                addr_d  = i_lsu_addr;
                wen_d   = i_lsu_wen;
                wdata_d = i_lsu_wdata;
                wmask_d = i_lsu_wmask;
                size_d  = i_lsu_size;
            end else if (ifu_win) begin
                owner_d = OWNER_IFU;
                addr_d  = i_ifu_addr;
                wen_d   = 1'b0;
                wdata_d = 32'd0;
                wmask_d = 4'd0;
                size_d  = IFU_SIZE;
            end

            // A flushed-but-valid fetch neither counts as waiting nor resets the streak.
            if (ifu_win || !i_ifu_req_valid) begin
                streak_d = 4'd0;
            end else if (lsu_win && ifu_live && streak_q != STREAK_MAX) begin
                streak_d = streak_q + 4'd1;
            end
        end else if (owner_q == OWNER_IFU && i_ifu_flush) begin
            drop_d = 1'b1;
        end

        if (bus_resp_hs) begin
            drop_d = 1'b0;
        end
    end

    always_comb begin
        o_ifu_req_ready  = ifu_win;
        o_lsu_req_ready  = lsu_win;

        o_bus_req_valid  = (state_q == ST_ISSUE);
        o_bus_addr       = addr_q;
        o_bus_wen        = wen_q;
        o_bus_wdata      = wdata_q;
        o_bus_wmask      = wmask_q;
        o_bus_size       = size_q;
        o_bus_resp_ready = resp_ready_w;

        o_ifu_resp_valid = 1'b0;
        o_lsu_resp_valid = 1'b0;
        if (state_q == ST_WAIT) begin
            // A flush arriving with the response hides it from the IFU immediately.
            o_ifu_resp_valid = i_bus_resp_valid & (owner_q == OWNER_IFU) & ~drop_q & ~i_ifu_flush;
            o_lsu_resp_valid = i_bus_resp_valid & (owner_q == OWNER_LSU) & ~drop_q;
        end

        o_ifu_rdata = i_bus_rdata;
        o_lsu_rdata = i_bus_rdata;
        o_ifu_err   = o_ifu_resp_valid & i_bus_err;
        o_lsu_err   = o_lsu_resp_valid & i_bus_err;

        o_busy  = (state_q != ST_IDLE);
        o_owner = owner_q;
    end

endmodule

// File: tb/tb_ysyx_24110006_mem_arbiter.sv
module tb_ysyx_24110006_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ifu_req_valid, o_ifu_req_ready, i_ifu_flush;
    logic [31:0] i_ifu_addr;
    logic        o_ifu_resp_valid, i_ifu_resp_ready, o_ifu_err;
    logic [31:0] o_ifu_rdata;
    logic        i_lsu_req_valid, o_lsu_req_ready, i_lsu_wen;
    logic [31:0] i_lsu_addr, i_lsu_wdata;
    logic [3:0]  i_lsu_wmask;
    logic [2:0]  i_lsu_size;
    logic        o_lsu_resp_valid, i_lsu_resp_ready, o_lsu_err;
    logic [31:0] o_lsu_rdata;
    logic        o_bus_req_valid, i_bus_req_ready, o_bus_wen;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_wmask;
    logic [2:0]  o_bus_size;
    logic        i_bus_resp_valid, o_bus_resp_ready, i_bus_err;
    logic [31:0] i_bus_rdata;
    logic        o_busy, o_owner;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_24110006_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_LSU_STREAK(MAX_STREAK)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_ifu_req_valid(i_ifu_req_valid), .o_ifu_req_ready(o_ifu_req_ready),
        .i_ifu_addr(i_ifu_addr), .i_ifu_flush(i_ifu_flush),
        .o_ifu_resp_valid(o_ifu_resp_valid), .i_ifu_resp_ready(i_ifu_resp_ready),
        .o_ifu_rdata(o_ifu_rdata), .o_ifu_err(o_ifu_err),
        .i_lsu_req_valid(i_lsu_req_valid), .o_lsu_req_ready(o_lsu_req_ready),
        .i_lsu_addr(i_lsu_addr), .i_lsu_wen(i_lsu_wen), .i_lsu_wdata(i_lsu_wdata),
        .i_lsu_wmask(i_lsu_wmask), .i_lsu_size(i_lsu_size),
        .o_lsu_resp_valid(o_lsu_resp_valid), .i_lsu_resp_ready(i_lsu_resp_ready),
        .o_lsu_rdata(o_lsu_rdata), .o_lsu_err(o_lsu_err),
        .o_bus_req_valid(o_bus_req_valid), .i_bus_req_ready(i_bus_req_ready),
        .o_bus_addr(o_bus_addr), .o_bus_wen(o_bus_wen), .o_bus_wdata(o_bus_wdata),
        .o_bus_wmask(o_bus_wmask), .o_bus_size(o_bus_size),
        .i_bus_resp_valid(i_bus_resp_valid), .o_bus_resp_ready(o_bus_resp_ready),
        .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err),
        .o_busy(o_busy), .o_owner(o_owner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        i_ifu_req_valid = 0; i_ifu_addr = 0; i_ifu_flush = 0; i_ifu_resp_ready = 0;
        i_lsu_req_valid = 0; i_lsu_addr = 0; i_lsu_wen = 0; i_lsu_wdata = 0;
        i_lsu_wmask = 0; i_lsu_size = 0; i_lsu_resp_ready = 0;
        i_bus_req_ready = 0; i_bus_resp_valid = 0; i_bus_rdata = 0; i_bus_err = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        i_ifu_req_valid = 1;
        i_bus_resp_valid = 1;
        i_ifu_resp_ready = 1;
        #1;
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        checks++; if (o_bus_req_valid !== 1'b0) begin failures++; $display("FAIL rst_bus_req_valid got=%b exp=0", o_bus_req_valid); end
        checks++; if ({o_ifu_resp_valid, o_lsu_resp_valid, o_bus_resp_ready} !== 3'b000) begin failures++; $display("FAIL rst_resp got=%b exp=000", {o_ifu_resp_valid, o_lsu_resp_valid, o_bus_resp_ready}); end
        checks++; if ({o_ifu_req_ready, o_lsu_req_ready} !== 2'b10) begin failures++; $display("FAIL rst_grant_ifu got=%b exp=10", {o_ifu_req_ready, o_lsu_req_ready}); end
        i_lsu_req_valid = 1;
        #1;
        checks++; if ({o_ifu_req_ready, o_lsu_req_ready} !== 2'b01) begin failures++; $display("FAIL rst_grant_lsu got=%b exp=01", {o_ifu_req_ready, o_lsu_req_ready}); end
        tick();
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_held_busy got=%b exp=0", o_busy); end
        clear_inputs();
        rst = 0;
    endtask

    task automatic test_ifu_only();
        do_reset();
        i_ifu_req_valid = 1; i_ifu_addr = 32'h8000_0000; i_ifu_resp_ready = 1;
        i_bus_req_ready = 1; i_bus_resp_valid = 1; i_bus_rdata = 32'h0000_0413;
        settle();
        checks++; if (o_ifu_req_ready !== 1'b1) begin failures++; $display("FAIL t1_c0_ifu_ready got=%b exp=1", o_ifu_req_ready); end
        checks++; if (o_ifu_resp_valid !== 1'b0) begin failures++; $display("FAIL t1_c0_resp_valid got=%b exp=0", o_ifu_resp_valid); end
        tick(); i_ifu_req_valid = 0; settle();
        checks++; if (o_bus_req_valid !== 1'b1) begin failures++; $display("FAIL t1_c1_bus_req_valid got=%b exp=1", o_bus_req_valid); end
        checks++; if ({o_bus_addr, o_bus_wen, o_bus_wmask, o_bus_size} !== {32'h8000_0000, 1'b0, 4'b0000, 3'b010}) begin failures++; $display("FAIL t1_c1_payload got=%h/%b/%b/%b exp=80000000/0/0000/010", o_bus_addr, o_bus_wen, o_bus_wmask, o_bus_size); end
        checks++; if ({o_owner, o_ifu_resp_valid} !== 2'b00) begin failures++; $display("FAIL t1_c1_owner_resp got=%b exp=00", {o_owner, o_ifu_resp_valid}); end
        tick(); settle();
        checks++; if (o_ifu_resp_valid !== 1'b1 || o_ifu_rdata !== 32'h0000_0413) begin failures++; $display("FAIL t1_c2_resp got=%b/%h exp=1/00000413", o_ifu_resp_valid, o_ifu_rdata); end
        checks++; if ({o_bus_resp_ready, o_lsu_resp_valid, o_ifu_err} !== 3'b100) begin failures++; $display("FAIL t1_c2_side got=%b exp=100", {o_bus_resp_ready, o_lsu_resp_valid, o_ifu_err}); end
        tick(); settle();
        checks++; if ({o_busy, o_bus_req_valid} !== 2'b00) begin failures++; $display("FAIL t1_c3_idle got=%b exp=00", {o_busy, o_bus_req_valid}); end
        clear_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        i_ifu_req_valid = 1; i_ifu_addr = 32'h8000_0040; i_ifu_resp_ready = 1;
        i_lsu_req_valid = 1; i_lsu_addr = 32'h8000_1000; i_lsu_wen = 1; i_lsu_wdata = 32'h1234_5678;
        i_lsu_wmask = 4'b0011; i_lsu_size = 3'b001; i_lsu_resp_ready = 1;
        i_bus_req_ready = 1; i_bus_resp_valid = 1; i_bus_rdata = 32'h0;
        settle();
        checks++; if ({o_ifu_req_ready, o_lsu_req_ready} !== 2'b01) begin failures++; $display("FAIL t2_lsu_first got=%b exp=01", {o_ifu_req_ready, o_lsu_req_ready}); end
        tick(); i_lsu_req_valid = 0; settle();
        checks++; if ({o_bus_req_valid, o_bus_wen, o_bus_wmask, o_owner} !== {1'b1, 1'b1, 4'b0011, 1'b1}) begin failures++; $display("FAIL t2_store_ctl got=%b exp=1100111", {o_bus_req_valid, o_bus_wen, o_bus_wmask, o_owner}); end
        checks++; if ({o_bus_addr, o_bus_wdata, o_bus_size} !== {32'h8000_1000, 32'h1234_5678, 3'b001}) begin failures++; $display("FAIL t2_store_data got=%h/%h/%b exp=80001000/12345678/001", o_bus_addr, o_bus_wdata, o_bus_size); end
        checks++; if (o_ifu_req_ready !== 1'b0) begin failures++; $display("FAIL t2_ifu_blocked got=%b exp=0", o_ifu_req_ready); end
        tick(); settle();
        checks++; if ({o_lsu_resp_valid, o_ifu_resp_valid} !== 2'b10) begin failures++; $display("FAIL t2_lsu_resp got=%b exp=10", {o_lsu_resp_valid, o_ifu_resp_valid}); end
        tick(); settle();
        checks++; if ({o_busy, o_ifu_req_ready} !== 2'b01) begin failures++; $display("FAIL t2_ifu_next got=%b exp=01", {o_busy, o_ifu_req_ready}); end
        tick(); i_ifu_req_valid = 0; settle();
        checks++; if ({o_bus_addr, o_bus_wen, o_owner} !== {32'h8000_0040, 1'b0, 1'b0}) begin failures++; $display("FAIL t2_ifu_issue got=%h/%b/%b exp=80000040/0/0", o_bus_addr, o_bus_wen, o_owner); end
        tick(); settle();
        checks++; if (o_ifu_resp_valid !== 1'b1) begin failures++; $display("FAIL t2_ifu_resp got=%b exp=1", o_ifu_resp_valid); end
        tick();
        clear_inputs();
    endtask

    task automatic test_starvation();
        bit got[10];
        int n = 0;
        do_reset();
        i_ifu_req_valid = 1; i_ifu_addr = 32'h8000_0100; i_ifu_resp_ready = 1;
        i_lsu_req_valid = 1; i_lsu_addr = 32'h8000_2000; i_lsu_resp_ready = 1;
        i_bus_req_ready = 1; i_bus_resp_valid = 1;
        settle();
        for (int cyc = 0; cyc < 80 && n < 10; cyc++) begin
            if (o_lsu_req_ready) begin got[n] = 1'b1; n++; end
            else if (o_ifu_req_ready) begin got[n] = 1'b0; n++; end
            tick(); settle();
        end
        checks++; if (n != 10) begin failures++; $display("FAIL t3_grant_count got=%0d exp=10", n); end
        for (int k = 0; k < n; k++) begin
            // every (MAX+1)th grant goes to the starving fetch
            checks++;
            if (got[k] !== ((k % (MAX_STREAK + 1)) != MAX_STREAK)) begin
                failures++; $display("FAIL t3_order idx=%0d got_lsu=%b exp_lsu=%b", k, got[k], (k % (MAX_STREAK + 1)) != MAX_STREAK);
            end
        end
        clear_inputs();
        tick();
        tick();
        tick();
    endtask

    task automatic test_flush_drop();
        do_reset();
        i_ifu_req_valid = 1; i_ifu_addr = 32'h8000_0200; i_bus_req_ready = 1;
        settle();
        checks++; if (o_ifu_req_ready !== 1'b1) begin failures++; $display("FAIL t4_grant got=%b exp=1", o_ifu_req_ready); end
        tick(); i_ifu_req_valid = 0; settle();
        tick(); i_ifu_flush = 1; settle();
        checks++; if ({o_busy, o_ifu_resp_valid} !== 2'b10) begin failures++; $display("FAIL t4_wait_flush got=%b exp=10", {o_busy, o_ifu_resp_valid}); end
        tick(); i_ifu_flush = 0; settle();
        tick(); settle();
        tick(); i_bus_resp_valid = 1; i_bus_rdata = 32'hDEAD_BEEF; settle();
        checks++; if ({o_ifu_resp_valid, o_lsu_resp_valid, o_bus_resp_ready} !== 3'b001) begin failures++; $display("FAIL t4_drop_resp got=%b exp=001", {o_ifu_resp_valid, o_lsu_resp_valid, o_bus_resp_ready}); end
        tick(); i_bus_resp_valid = 0; settle();
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL t4_back_idle got=%b exp=0", o_busy); end

        // flush in IDLE blocks the fetch grant for that cycle only
        i_ifu_req_valid = 1; i_ifu_flush = 1; settle();
        checks++; if (o_ifu_req_ready !== 1'b0) begin failures++; $display("FAIL t4_idle_flush got=%b exp=0", o_ifu_req_ready); end
        tick(); i_ifu_flush = 0; settle();
        checks++; if (o_ifu_req_ready !== 1'b1) begin failures++; $display("FAIL t4_idle_after got=%b exp=1", o_ifu_req_ready); end
        tick(); i_ifu_req_valid = 0; settle();
        tick(); i_bus_resp_valid = 1; i_ifu_resp_ready = 1; i_ifu_flush = 1; settle();
        checks++; if ({o_ifu_resp_valid, o_bus_resp_ready} !== 2'b01) begin failures++; $display("FAIL t4_flush_at_resp got=%b exp=01", {o_ifu_resp_valid, o_bus_resp_ready}); end
        tick(); clear_inputs(); settle();
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL t4_idle2 got=%b exp=0", o_busy); end

        // flush while the LSU owns the bus changes nothing
        i_lsu_req_valid = 1; i_lsu_addr = 32'h8000_3000; i_bus_req_ready = 1; i_lsu_resp_ready = 1;
        tick(); i_lsu_req_valid = 0; i_ifu_flush = 1; settle();
        tick(); i_bus_resp_valid = 1; settle();
        checks++; if ({o_lsu_resp_valid, o_ifu_resp_valid} !== 2'b10) begin failures++; $display("FAIL t4_lsu_flush got=%b exp=10", {o_lsu_resp_valid, o_ifu_resp_valid}); end
        tick();
        clear_inputs();
    endtask

    task automatic test_stall_err();
        do_reset();
        i_lsu_req_valid = 1; i_lsu_addr = 32'h8000_2004; i_lsu_wen = 0; i_lsu_size = 3'b100;
        settle();
        checks++; if (o_lsu_req_ready !== 1'b1) begin failures++; $display("FAIL t5_grant got=%b exp=1", o_lsu_req_ready); end
        tick(); i_lsu_req_valid = 0; i_lsu_addr = 32'h1111_1111; i_lsu_size = 3'b000;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++;
            if ({o_bus_req_valid, o_bus_addr, o_bus_size} !== {1'b1, 32'h8000_2004, 3'b100}) begin
                failures++; $display("FAIL t5_stall c=%0d got=%b/%h/%b exp=1/80002004/100", c, o_bus_req_valid, o_bus_addr, o_bus_size);
            end
            tick();
        end
        i_bus_req_ready = 1; settle();
        tick(); i_bus_req_ready = 0; i_bus_resp_valid = 1; i_bus_err = 1; i_bus_rdata = 32'hCAFE_0001; i_lsu_resp_ready = 1; settle();
        checks++; if ({o_lsu_resp_valid, o_lsu_err, o_ifu_err} !== 3'b110) begin failures++; $display("FAIL t5_err got=%b exp=110", {o_lsu_resp_valid, o_lsu_err, o_ifu_err}); end
        checks++; if (o_lsu_rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL t5_rdata got=%h exp=cafe0001", o_lsu_rdata); end
        tick(); clear_inputs(); settle();
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL t5_idle got=%b exp=0", o_busy); end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_ifu_req_valid = 1; i_ifu_addr = 32'h8000_0300; i_bus_req_ready = 1;
        tick(); i_ifu_req_valid = 0;
        tick(); i_bus_resp_valid = 1; i_ifu_resp_ready = 0; settle();
        checks++; if ({o_busy, o_ifu_resp_valid} !== 2'b11) begin failures++; $display("FAIL t6_in_wait got=%b exp=11", {o_busy, o_ifu_resp_valid}); end
        #1; rst = 1; #1;
        checks++; if ({o_busy, o_bus_req_valid, o_ifu_resp_valid, o_bus_resp_ready} !== 4'b0000) begin failures++; $display("FAIL t6_async got=%b exp=0000", {o_busy, o_bus_req_valid, o_ifu_resp_valid, o_bus_resp_ready}); end
        tick(); clear_inputs(); rst = 0;
        i_ifu_req_valid = 1; i_ifu_addr = 32'h8000_0400; settle();
        checks++; if (o_ifu_req_ready !== 1'b1) begin failures++; $display("FAIL t6_regrant got=%b exp=1", o_ifu_req_ready); end
        tick(); i_ifu_req_valid = 0; i_bus_req_ready = 1; settle();
        checks++; if ({o_bus_req_valid, o_bus_addr} !== {1'b1, 32'h8000_0400}) begin failures++; $display("FAIL t6_reissue got=%b/%h exp=1/80000400", o_bus_req_valid, o_bus_addr); end
        tick(); i_bus_resp_valid = 1; i_bus_rdata = 32'h0000_0013; i_ifu_resp_ready = 1; settle();
        checks++; if ({o_ifu_resp_valid, o_ifu_rdata} !== {1'b1, 32'h0000_0013}) begin failures++; $display("FAIL t6_resp got=%b/%h exp=1/00000013", o_ifu_resp_valid, o_ifu_rdata); end
        tick();
        clear_inputs();
    endtask

    // Transaction-level reference: one outstanding transaction, a starvation
    // count of LSU wins taken while fetch waited, and a "stale" mark for
    // flushed fetches.
    task automatic test_random();
        bit          busy = 0, sent = 0, owner_lsu = 0, stale = 0;
        int          starved = 0;
        logic [31:0] t_addr = 0, t_wdata = 0;
        logic        t_wen = 0;
        logic [3:0]  t_wmask = 0;
        logic [2:0]  t_size = 0;
        bit          ifu_live, e_lsu, e_ifu, waiting, e_irv, e_lrv, e_rr;
        logic [8:0]  got, exp;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_ifu_req_valid  = ($urandom_range(0, 3) != 0);
            i_ifu_addr       = $urandom;
            i_ifu_flush      = ($urandom_range(0, 9) == 0);
            i_ifu_resp_ready = 1'($urandom_range(0, 1));
            i_lsu_req_valid  = 1'($urandom_range(0, 1));
            i_lsu_addr       = $urandom;
            i_lsu_wen        = 1'($urandom_range(0, 1));
            i_lsu_wdata      = $urandom;
            i_lsu_wmask      = 4'($urandom);
            i_lsu_size       = 3'($urandom);
            i_lsu_resp_ready = 1'($urandom_range(0, 1));
            i_bus_req_ready  = ($urandom_range(0, 2) != 0);
            i_bus_resp_valid = 1'($urandom_range(0, 1));
            i_bus_rdata      = $urandom;
            i_bus_err        = ($urandom_range(0, 4) == 0);
            settle();

            ifu_live = i_ifu_req_valid && !i_ifu_flush;
            e_lsu    = !busy && i_lsu_req_valid && !(ifu_live && starved >= MAX_STREAK);
            e_ifu    = !busy && ifu_live && !e_lsu;
            waiting  = busy && sent;
            e_irv    = waiting && i_bus_resp_valid && !owner_lsu && !stale && !i_ifu_flush;
            e_lrv    = waiting && i_bus_resp_valid && owner_lsu && !stale;
            e_rr     = waiting && (stale || (owner_lsu ? i_lsu_resp_ready : i_ifu_resp_ready));
            exp = {busy, busy && !sent, e_ifu, e_lsu, e_irv, e_lrv, e_rr, e_irv && i_bus_err, e_lrv && i_bus_err};
            got = {o_busy, o_bus_req_valid, o_ifu_req_ready, o_lsu_req_ready, o_ifu_resp_valid,
                   o_lsu_resp_valid, o_bus_resp_ready, o_ifu_err, o_lsu_err};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", cyc, got, exp); end
            if (busy && !sent) begin
                checks++;
                if ({o_owner, o_bus_addr, o_bus_wen, o_bus_wmask, o_bus_size} !== {owner_lsu, t_addr, t_wen, t_wmask, t_size}
                    || (owner_lsu && o_bus_wdata !== t_wdata)) begin
                    failures++; $display("FAIL rnd_payload cyc=%0d got=%b/%h/%b/%b/%b/%h exp=%b/%h/%b/%b/%b/%h", cyc,
                        o_owner, o_bus_addr, o_bus_wen, o_bus_wmask, o_bus_size, o_bus_wdata,
                        owner_lsu, t_addr, t_wen, t_wmask, t_size, t_wdata);
                end
            end
            if (e_irv || e_lrv) begin
                checks++;
                if ((e_irv ? o_ifu_rdata : o_lsu_rdata) !== i_bus_rdata) begin
                    failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, e_irv ? o_ifu_rdata : o_lsu_rdata, i_bus_rdata);
                end
            end

            if (!busy) begin
                if (e_lsu) begin
                    busy = 1; sent = 0; owner_lsu = 1;
                    t_addr = i_lsu_addr; t_wen = i_lsu_wen; t_wdata = i_lsu_wdata; t_wmask = i_lsu_wmask; t_size = i_lsu_size;
                end else if (e_ifu) begin
                    busy = 1; sent = 0; owner_lsu = 0;
                    t_addr = i_ifu_addr; t_wen = 0; t_wdata = 0; t_wmask = 0; t_size = 3'b010;
                end
                if (e_ifu || !i_ifu_req_valid) starved = 0;
                else if (e_lsu && ifu_live && starved < MAX_STREAK) starved++;
            end else begin
                if (!sent) begin
                    if (i_bus_req_ready) sent = 1;
                end else if (i_bus_resp_valid && e_rr) begin
                    busy = 0; stale = 0;
                end
                if (busy && !owner_lsu && i_ifu_flush) stale = 1;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ifu_only();
        test_priority();
        test_starvation();
        test_flush_drop();
        test_stall_err();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
